// File: rtl/display_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : display_pkg                                                      |
// | Brief   : Shared types and constants for the BCD 7-segment display path.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_t;

    // Segment codes are g..a, active-high.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [1:0] AN_ONES = 2'b10;
    localparam logic [1:0] AN_TENS = 2'b01;
    localparam logic [1:0] AN_OFF  = 2'b11;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd6.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : bin2bcd6                                                         |
// | Brief   : Sequential 6-bit binary to two-digit BCD (shift-and-add-3).      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module bin2bcd6 (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] bin_in,
    output logic       busy,
    output logic       done,
    output logic [3:0] tens,
    output logic [3:0] ones
);
    import display_pkg::*;

    conv_state_t r_state;
    logic [5:0]  r_bin;
    logic [7:0]  r_scratch;
    logic [2:0]  r_count;
    logic [7:0]  w_adj;

    always_comb begin
        w_adj = r_scratch;
        if (r_scratch[3:0] >= 4'd5) w_adj[3:0] = r_scratch[3:0] + 4'd3;
        if (r_scratch[7:4] >= 4'd5) w_adj[7:4] = r_scratch[7:4] + 4'd3;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_bin     <= 6'd0;
            r_scratch <= 8'd0;
            r_count   <= 3'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            tens      <= 4'd0;
            ones      <= 4'd0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_bin     <= bin_in;
                        r_scratch <= 8'd0;
                        r_count   <= 3'd6;
                        busy      <= 1'b1;
                        r_state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // Scratch never exceeds 63 in BCD, so bit 7 of the adjusted value is always 0.
                    {r_scratch, r_bin} <= {w_adj[6:0], r_bin, 1'b0};
                    r_count            <= r_count - 3'd1;
                    if (r_count == 3'd1) r_state <= ST_DONE;
                end
                ST_DONE: begin
                    tens    <= r_scratch[7:4];
                    ones    <= r_scratch[3:0];
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/count_bcd_display.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : count_bcd_display                                                |
// | Brief   : Counter value to BCD, multiplexed onto a 2-digit 7-seg display.  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module count_bcd_display #(
    parameter int REFRESH_DIV = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] q_in,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       busy,
    output logic       done,
    output logic [6:0] seg,
    output logic [1:0] an
);
    import display_pkg::*;

    localparam int                 c_cnt_w   = $clog2(REFRESH_DIV);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(REFRESH_DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_sel;
    logic [5:0]         r_last;
    logic               r_force;
    logic               w_start;
    logic [3:0]         w_digit;
    logic [6:0]         w_pat;

    // A change seen while busy is picked up by the compare in the next idle cycle.
    always_comb begin
        w_start = (r_force || (q_in != r_last)) && !busy;
    end

    always_comb begin
        w_digit = r_sel ? tens : ones;
        w_pat   = seg_decode(w_digit);
        if (r_sel && (tens == 4'd0)) w_pat = SEG_BLANK;
    end

    bin2bcd6 u_conv (
        .clk    (clk),
        .reset  (reset),
        .start  (w_start),
        .bin_in (q_in),
        .busy   (busy),
        .done   (done),
        .tens   (tens),
        .ones   (ones)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_sel   <= 1'b0;
            r_last  <= 6'd0;
            r_force <= 1'b1;
            an      <= AN_OFF;
            seg     <= SEG_BLANK;
        end else begin
            if (r_cnt == c_cnt_max) begin
                r_cnt <= '0;
                r_sel <= ~r_sel;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            an  <= r_sel ? AN_TENS : AN_ONES;
            seg <= w_pat;
            if (w_start) begin
                r_last  <= q_in;
                r_force <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_count_bcd_display.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_count_bcd_display                                             |
// | Brief   : Self-checking bench for count_bcd_display.                       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_count_bcd_display;

    localparam int N = 4;

    logic       clk;
    logic       reset;
    logic [5:0] q_in;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       busy;
    logic       done;
    logic [6:0] seg;
    logic [1:0] an;

    int checks   = 0;
    int failures = 0;

    count_bcd_display #(.REFRESH_DIV(N)) dut (
        .clk   (clk),
        .reset (reset),
        .q_in  (q_in),
        .tens  (tens),
        .ones  (ones),
        .busy  (busy),
        .done  (done),
        .seg   (seg),
        .an    (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] pat(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0: p = 7'h3F; 4'd1: p = 7'h06; 4'd2: p = 7'h5B; 4'd3: p = 7'h4F;
            4'd4: p = 7'h66; 4'd5: p = 7'h6D; 4'd6: p = 7'h7D; 4'd7: p = 7'h07;
            4'd8: p = 7'h7F; 4'd9: p = 7'h6F; default: p = 7'h00;
        endcase
        return p;
    endfunction

    // Display model: slot index from edges since reset release, digits as they stood before the edge.
    int         k = 0;
    logic [3:0] prev_t, prev_o;
    bit         mon_en = 1'b0;
    int         busy_run = 0;
    bit         prev_done = 1'b0;
    logic [1:0] ea;
    logic [6:0] es;

    always @(posedge clk) begin
        prev_t = tens;
        prev_o = ones;
        if (!reset) k = 0;
        else        k++;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (k == 0) begin
                ea = 2'b11; es = 7'h00;
            end else if ((((k - 1) / N) % 2) == 0) begin
                ea = 2'b10; es = pat(prev_o);
            end else begin
                ea = 2'b01; es = (prev_t == 4'd0) ? 7'h00 : pat(prev_t);
            end
            check("an", int'(an), int'(ea));
            check("seg", int'(seg), int'(es));
            if (busy) busy_run++;
            else begin
                if (busy_run > 0) check("busy_run_over7", int'(busy_run > 7), 0);
                busy_run = 0;
            end
            if (done) check("done_width", int'(prev_done), 0);
            prev_done = done;
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 40);
        if (!done) check("done_timeout", 0, 1);
    endtask

    typedef struct {
        logic [5:0] q;
        logic [3:0] t;
        logic [3:0] o;
    } vec_t;

    vec_t vecs [7];
    int   n, len, pulses, v;
    logic [3:0] pt [4];
    logic [3:0] po [4];

    initial begin
        vecs[0] = '{6'd37, 4'd3, 4'd7};
        vecs[1] = '{6'd63, 4'd6, 4'd3};
        vecs[2] = '{6'd9,  4'd0, 4'd9};
        vecs[3] = '{6'd10, 4'd1, 4'd0};
        vecs[4] = '{6'd59, 4'd5, 4'd9};
        vecs[5] = '{6'd42, 4'd4, 4'd2};
        vecs[6] = '{6'd20, 4'd2, 4'd0};

        reset = 1'b0;
        q_in  = 6'd0;
        @(negedge clk);
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_tens", int'(tens), 0);
        check("rst_ones", int'(ones), 0);
        check("rst_seg",  int'(seg), 0);
        check("rst_an",   int'(an), 3);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);

        reset = 1'b1;
        wait_done(n);
        check("first_latency", n, 8);
        check("first_tens", int'(tens), 0);
        check("first_ones", int'(ones), 0);
        @(negedge clk);
        check("first_done_fall", int'(done), 0);

        for (int i = 0; i < 7; i++) begin
            q_in = vecs[i].q;
            wait_done(n);
            check("vec_latency", n, 8);
            check("vec_tens", int'(tens), int'(vecs[i].t));
            check("vec_ones", int'(ones), int'(vecs[i].o));
            @(negedge clk);
            check("vec_done_fall", int'(done), 0);
        end

        // Leading-zero blanking and slot length.
        q_in = 6'd5;
        wait_done(n);
        check("blank_ones", int'(ones), 5);
        len = 0;
        while (an == 2'b01 && len < 20) begin @(negedge clk); len++; end
        len = 0;
        while (an != 2'b01 && len < 20) begin @(negedge clk); len++; end
        len = 0;
        while (an == 2'b01 && len < 20) begin
            check("blank_tens_seg", int'(seg), 0);
            @(negedge clk);
            len++;
        end
        check("tens_slot_len", len, N);
        len = 0;
        while (an == 2'b10 && len < 20) begin
            check("ones_slot_seg", int'(seg), 'h6D);
            @(negedge clk);
            len++;
        end
        check("ones_slot_len", len, N);

        // Input change while the converter is busy.
        q_in = 6'd10;
        repeat (3) @(negedge clk);
        q_in = 6'd11;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) begin
                if (pulses < 4) begin pt[pulses] = tens; po[pulses] = ones; end
                pulses++;
            end
        end
        check("mid_pulses", pulses, 2);
        check("mid_first_tens",  int'(pt[0]), 1);
        check("mid_first_ones",  int'(po[0]), 0);
        check("mid_second_tens", int'(pt[1]), 1);
        check("mid_second_ones", int'(po[1]), 1);

        // Reset in the middle of a conversion.
        q_in = 6'd42;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("abort_no_done", int'(done), 0);
        end
        check("abort_tens", int'(tens), 0);
        check("abort_ones", int'(ones), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_an",   int'(an), 3);
        check("abort_seg",  int'(seg), 0);
        reset = 1'b1;
        wait_done(n);
        check("abort_latency", n, 8);
        check("abort_tens_after", int'(tens), 4);
        check("abort_ones_after", int'(ones), 2);
        @(negedge clk);

        for (int s = 0; s < 64; s++) begin
            q_in = 6'(s);
            wait_done(n);
            check("sweep_value", int'(tens) * 10 + int'(ones), s);
            @(negedge clk);
        end

        // Random bursts of changes, then settle and compare against the held value.
        for (int b = 0; b < 25; b++) begin
            repeat ($urandom_range(1, 6)) begin
                q_in = 6'($urandom_range(0, 63));
                repeat ($urandom_range(1, 10)) @(negedge clk);
            end
            v = int'(q_in);
            repeat (20) @(negedge clk);
            check("rand_tens", int'(tens), v / 10);
            check("rand_ones", int'(ones), v % 10);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
